move_path_reader: RTL and testbench

MOVE_PATH_READER -- requirements
Module: move_path_reader

---
 rtl/move_path_reader_pkg.sv | 19 +
 rtl/move_path_reader_path_store.sv | 28 ++
 rtl/move_path_reader.sv | 136 +++++++++++++
 tb/tb_move_path_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_path_reader_pkg.sv
// Shared maze types: move codes, move width and the path-reader FSM encoding.
package move_path_reader_pkg;

    localparam int unsigned MOVE_CODE_W = 2;

    typedef enum logic [MOVE_CODE_W-1:0] {
        MOVE_UP    = 2'd0,
        MOVE_RIGHT = 2'd1,
        MOVE_DOWN  = 2'd2,
        MOVE_LEFT  = 2'd3
    } move_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPLAY = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/move_path_reader_path_store.sv
// Path entry array: one write/overwrite port, one asynchronous read port.
module path_store
    import move_path_reader_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MOVE_W = MOVE_CODE_W,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  wrAddr,
    input  logic [MOVE_W-1:0] wrData,
    input  logic [IDX_W-1:0]  rdAddr,
    output logic [MOVE_W-1:0] rdData
);

    // Contents are not reset; count==0 hides any stale entries.
    logic [MOVE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/move_path_reader.sv
// Solver path buffer: push/pop moves while idle, then replay them oldest-first
// over a valid/ready stream without disturbing the stored path.
module move_path_reader
    import move_path_reader_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MOVE_W = MOVE_CODE_W,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [MOVE_W-1:0] move_in,
    input  logic              clear,
    input  logic              start_replay,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [MOVE_W-1:0] move_out,
    output logic              replay_done,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              busy
);

    state_e            state;
    logic [IDX_W-1:0]  readIdx;
    logic [CNT_W-1:0]  countNext;
    logic              isIdle;
    logic              takePush;
    logic              takePop;
    logic              overwrite;
    logic              wrEn;
    logic [IDX_W-1:0]  wrAddr;
    logic [IDX_W-1:0]  rdAddr;
    logic [IDX_W-1:0]  lastIdx;
    logic [MOVE_W-1:0] rdData;

    // Command priority in IDLE: start_replay > clear > push/pop.
    assign isIdle    = (state == ST_IDLE);
    assign takePush  = isIdle && push && !start_replay && !clear;
    assign takePop   = isIdle && pop && !start_replay && !clear;
    assign overwrite = takePush && takePop && !empty;
    assign wrEn      = overwrite || (takePush && !full);
    assign wrAddr    = overwrite ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);
    assign lastIdx   = IDX_W'(count - CNT_W'(1));

    // Read one entry ahead so move_out can be registered on each advance.
    assign rdAddr    = isIdle ? '0 : readIdx + IDX_W'(1);

    path_store #(
        .DEPTH  (DEPTH),
        .MOVE_W (MOVE_W)
    ) u_store (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wrAddr),
        .wrData (move_in),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    always_comb begin
        countNext = count;
        if (isIdle && !start_replay) begin
            if (clear) begin
                countNext = '0;
            end else if (overwrite) begin
                countNext = count;
            end else if (takePush) begin
                if (!full) begin
                    countNext = count + CNT_W'(1);
                end
            end else if (takePop && !empty) begin
                countNext = count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            readIdx     <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            out_valid   <= 1'b0;
            move_out    <= '0;
            replay_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            count       <= countNext;
            full        <= (countNext == CNT_W'(DEPTH));
            empty       <= (countNext == '0);
            replay_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_replay) begin
                        busy    <= 1'b1;
                        readIdx <= '0;
                        if (count != '0) begin
                            state     <= ST_REPLAY;
                            out_valid <= 1'b1;
                            move_out  <= rdData;
                        end else begin
                            state       <= ST_DONE;
                            replay_done <= 1'b1;
                        end
                    end
                end
                ST_REPLAY: begin
                    if (out_ready) begin
                        if (readIdx == lastIdx) begin
                            state       <= ST_DONE;
                            out_valid   <= 1'b0;
                            replay_done <= 1'b1;
                        end else begin
                            readIdx  <= readIdx + IDX_W'(1);
                            move_out <= rdData;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_path_reader.sv
// Directed bench for move_path_reader with hand-computed expected values.
module tb_move_path_reader;
    import move_path_reader_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned MOVE_W = 2;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              push;
    logic              pop;
    logic [MOVE_W-1:0] move_in;
    logic              clear;
    logic              start_replay;
    logic              out_ready;
    logic              out_valid;
    logic [MOVE_W-1:0] move_out;
    logic              replay_done;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              busy;

    int nTests = 0;
    int nFail  = 0;

    move_path_reader #(
        .DEPTH  (DEPTH),
        .MOVE_W (MOVE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .move_in      (move_in),
        .clear        (clear),
        .start_replay (start_replay),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .move_out     (move_out),
        .replay_done  (replay_done),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushMove(input logic [MOVE_W-1:0] m);
        push    = 1'b1;
        move_in = m;
        step();
        push    = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        move_in      = '0;
        clear        = 1'b0;
        start_replay = 1'b0;
        out_ready    = 1'b0;

        step();
        step();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_done", 32'(replay_done), 0);
        rst_n = 1'b1;
        step();

        // Basic push 1,2,3 and full-speed replay.
        pushMove(MOVE_RIGHT);
        pushMove(MOVE_DOWN);
        pushMove(MOVE_LEFT);
        check("push3_count", 32'(count), 3);
        check("push3_empty", 32'(empty), 0);
        start_replay = 1'b1;
        out_ready    = 1'b1;
        step();
        start_replay = 1'b0;
        check("r1_valid", 32'(out_valid), 1);
        check("r1_busy", 32'(busy), 1);
        check("r1_m0", 32'(move_out), 1);
        step();
        check("r1_m1", 32'(move_out), 2);
        step();
        check("r1_m2", 32'(move_out), 3);
        check("r1_nodone", 32'(replay_done), 0);
        step();
        check("r1_done", 32'(replay_done), 1);
        check("r1_valid_off", 32'(out_valid), 0);
        check("r1_count", 32'(count), 3);
        step();
        check("r1_done_pulse", 32'(replay_done), 0);
        check("r1_idle", 32'(busy), 0);

        // Second replay shows the path survived.
        start_replay = 1'b1;
        step();
        start_replay = 1'b0;
        check("r2_m0", 32'(move_out), 1);
        step();
        step();
        check("r2_m2", 32'(move_out), 3);
        step();
        check("r2_done", 32'(replay_done), 1);
        step();
        out_ready = 1'b0;
        doClear();
        check("clr_count", 32'(count), 0);
        check("clr_empty", 32'(empty), 1);

        // Fill to DEPTH, then one extra push of 0 is dropped.
        for (int i = 0; i < 16; i++) begin
            pushMove(MOVE_W'(i % 4));
        end
        check("fill_full", 32'(full), 1);
        pushMove(MOVE_UP);
        check("fill_count", 32'(count), 16);
        check("fill_full2", 32'(full), 1);
        start_replay = 1'b1;
        out_ready    = 1'b1;
        step();
        start_replay = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill_m%0d", i), 32'(move_out), 32'(i % 4));
            step();
        end
        check("fill_done", 32'(replay_done), 1);
        check("fill_no17", 32'(out_valid), 0);
        step();
        out_ready = 1'b0;
        doClear();

        // Push+pop overwrites the top entry; pop on empty is ignored.
        pushMove(MOVE_UP);
        pushMove(MOVE_RIGHT);
        push    = 1'b1;
        pop     = 1'b1;
        move_in = MOVE_LEFT;
        step();
        push = 1'b0;
        pop  = 1'b0;
        check("ovw_count", 32'(count), 2);
        start_replay = 1'b1;
        out_ready    = 1'b1;
        step();
        start_replay = 1'b0;
        check("ovw_m0", 32'(move_out), 0);
        step();
        check("ovw_m1", 32'(move_out), 3);
        step();
        check("ovw_done", 32'(replay_done), 1);
        step();
        out_ready = 1'b0;
        pop = 1'b1;
        step();
        check("pop_keep", 32'(count), 1);
        step();
        check("pop_to0", 32'(count), 0);
        step();
        pop = 1'b0;
        check("pop_empty", 32'(count), 0);
        check("pop_empty_flag", 32'(empty), 1);
        push    = 1'b1;
        pop     = 1'b1;
        move_in = MOVE_DOWN;
        step();
        push = 1'b0;
        pop  = 1'b0;
        check("pp_empty_push", 32'(count), 1);
        doClear();

        // Backpressure on the first entry; push during replay is ignored.
        pushMove(MOVE_DOWN);
        pushMove(MOVE_RIGHT);
        start_replay = 1'b1;
        out_ready    = 1'b0;
        step();
        start_replay = 1'b0;
        push         = 1'b1;
        move_in      = MOVE_LEFT;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
            check($sformatf("bp_hold%0d", i), 32'(move_out), 2);
            if (i < 2) step();
        end
        out_ready = 1'b1;
        push      = 1'b0;
        step();
        check("bp_m1", 32'(move_out), 1);
        step();
        check("bp_done", 32'(replay_done), 1);
        check("bp_count", 32'(count), 2);
        step();
        out_ready = 1'b0;
        doClear();

        // Empty replay goes straight to a single done pulse.
        start_replay = 1'b1;
        step();
        start_replay = 1'b0;
        check("e_valid", 32'(out_valid), 0);
        check("e_done", 32'(replay_done), 1);
        check("e_busy", 32'(busy), 1);
        step();
        check("e_done_once", 32'(replay_done), 0);
        check("e_valid2", 32'(out_valid), 0);
        check("e_idle", 32'(busy), 0);

        // Reset in the middle of a replay.
        pushMove(MOVE_RIGHT);
        pushMove(MOVE_DOWN);
        pushMove(MOVE_LEFT);
        start_replay = 1'b1;
        step();
        start_replay = 1'b0;
        out_ready    = 1'b1;
        step();
        out_ready = 1'b0;
        check("mr_at1", 32'(move_out), 2);
        rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_valid", 32'(out_valid), 0);
        check("mr_count", 32'(count), 0);
        check("mr_empty", 32'(empty), 1);
        check("mr_done", 32'(replay_done), 0);
        step();
        check("mr_done2", 32'(replay_done), 0);
        rst_n = 1'b1;
        step();
        check("mr_done3", 32'(replay_done), 0);
        check("mr_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
